// File: rtl/pc_unit_pkg.sv
// pc_unit_pkg: shared mode encoding and default addresses for the program counter
package pc_unit_pkg;

    typedef enum logic [2:0] {
        PC_HOLD   = 3'd0,
        PC_INCR   = 3'd1,
        PC_JUMP   = 3'd2,
        PC_BRANCH = 3'd3,
        PC_CALL   = 3'd4,
        PC_RET    = 3'd5,
        PC_TRAP   = 3'd6,
        PC_MRET   = 3'd7
    } pc_mode_e;

    localparam int          INSTRUCTION_SIZE_IN_BYTES = 4;
    localparam int          PC_RAS_DEPTH              = 4;
    localparam logic [31:0] PC_INIT_ADDR              = 32'h0000_0000;
    localparam logic [31:0] PC_TRAP_VEC               = 32'h0000_0100;

endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack; a push when full overwrites the oldest entry
module pc_ras #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            res_n,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] push_data,
    output logic [XLEN-1:0] top,
    output logic            empty,
    output logic            full
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = $clog2(RAS_DEPTH + 1);

    if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("pc_ras: RAS_DEPTH must be a power of two and at least 2");
    end

    logic [XLEN-1:0] mem_q [RAS_DEPTH];
    logic [PW-1:0]   ptr_q, ptr_d, wr_ptr;
    logic [CW-1:0]   cnt_q, cnt_d;

    assign wr_ptr = ptr_q + PW'(1);
    assign top    = mem_q[ptr_q];
    assign empty  = cnt_q == '0;
    assign full   = cnt_q == CW'(RAS_DEPTH);

    // pointer tracks the top entry; count saturates so the oldest entry is silently lost
    always_comb begin
        ptr_d = push ? wr_ptr : pop ? ptr_q - PW'(1) : ptr_q;
        cnt_d = push ? (full ? cnt_q : cnt_q + CW'(1)) : pop ? cnt_q - CW'(1) : cnt_q;
    end

    // pointer and count registers
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    // entry storage needs no reset; empty/full gate every read
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: program counter with return-address stack, trap entry and trap return
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] INIT_ADDR  = PC_INIT_ADDR,
    parameter logic [XLEN-1:0] TRAP_VEC   = PC_TRAP_VEC,
    parameter int              STEP_BYTES = INSTRUCTION_SIZE_IN_BYTES,
    parameter int              RAS_DEPTH  = PC_RAS_DEPTH
) (
    input  logic            clk,
    input  logic            res_n,
    input  logic            enable,
    input  logic [2:0]      mode,
    input  logic [XLEN-1:0] jmp_addr,
    input  logic [XLEN-1:0] offset,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_step,
    output logic [XLEN-1:0] epc,
    output logic            ras_empty,
    output logic            ras_full,
    output logic            misaligned,
    output logic            ras_underflow
);

    if (STEP_BYTES != 2 && STEP_BYTES != 4) begin : g_bad_step
        $error("pc_unit: STEP_BYTES must be 2 or 4");
    end

    localparam logic [XLEN-1:0] STEP  = XLEN'(STEP_BYTES);
    localparam logic [XLEN-1:0] AMASK = XLEN'(STEP_BYTES - 1);

    pc_mode_e        mode_e;
    logic [XLEN-1:0] pc_q, pc_d, epc_q, epc_d, target, ras_top;
    logic            mis_q, mis_d, uf_q, uf_d;
    logic            checked, bad, push, pop;

    assign mode_e        = pc_mode_e'(mode);
    assign pc            = pc_q;
    assign pc_step       = pc_q + STEP;
    assign epc           = epc_q;
    assign misaligned    = mis_q;
    assign ras_underflow = uf_q;

    // select the target, flag misalignment and decide stack traffic for this edge
    always_comb begin
        target = pc_q;
        unique case (mode_e)
            PC_INCR:          target = pc_step;
            PC_JUMP, PC_CALL: target = jmp_addr;
            PC_BRANCH:        target = pc_q + offset;
            PC_RET:           target = ras_empty ? pc_step : ras_top;
            PC_MRET:          target = epc_q;
            default:          target = pc_q;
        endcase
        checked = mode_e inside {PC_JUMP, PC_BRANCH, PC_CALL, PC_RET, PC_MRET};
        bad     = checked && (target & AMASK) != '0;
        push    = enable && mode_e == PC_CALL && !bad;
        pop     = enable && mode_e == PC_RET && !ras_empty && !bad;
        mis_d   = enable && bad;
        uf_d    = enable && mode_e == PC_RET && ras_empty && !bad;
        pc_d    = !enable ? pc_q : (mode_e == PC_TRAP || bad) ? TRAP_VEC : target;
        epc_d   = (enable && (mode_e == PC_TRAP || bad)) ? pc_q : epc_q;
    end

    // architectural registers and the one-cycle status pulses
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            pc_q  <= INIT_ADDR;
            epc_q <= '0;
            mis_q <= 1'b0;
            uf_q  <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            epc_q <= epc_d;
            mis_q <= mis_d;
            uf_q  <= uf_d;
        end
    end

    pc_ras #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .res_n     (res_n),
        .push      (push),
        .pop       (pop),
        .push_data (pc_step),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full)
    );

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: two pc_unit builds (4-byte and 2-byte step) against a queue-based reference model
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        res_n;
    logic        enable;
    logic [2:0]  mode;
    logic [31:0] jmp_addr, offset;

    logic [31:0] pc_w [2];
    logic [31:0] step_w [2];
    logic [31:0] epc_w [2];
    logic        emp_w [2];
    logic        full_w [2];
    logic        mis_w [2];
    logic        uf_w [2];

    logic [31:0] m_pc [2];
    logic [31:0] m_epc [2];
    logic        m_mis [2];
    logic        m_uf [2];
    logic [31:0] m_ras [2][$];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pc_unit #(.STEP_BYTES(4)) u_pc4 (
        .clk(clk), .res_n(res_n), .enable(enable), .mode(mode),
        .jmp_addr(jmp_addr), .offset(offset),
        .pc(pc_w[0]), .pc_step(step_w[0]), .epc(epc_w[0]),
        .ras_empty(emp_w[0]), .ras_full(full_w[0]),
        .misaligned(mis_w[0]), .ras_underflow(uf_w[0])
    );

    pc_unit #(.STEP_BYTES(2)) u_pc2 (
        .clk(clk), .res_n(res_n), .enable(enable), .mode(mode),
        .jmp_addr(jmp_addr), .offset(offset),
        .pc(pc_w[1]), .pc_step(step_w[1]), .epc(epc_w[1]),
        .ras_empty(emp_w[1]), .ras_full(full_w[1]),
        .misaligned(mis_w[1]), .ras_underflow(uf_w[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            logic [31:0] st;
            st = k == 0 ? 32'd4 : 32'd2;
            check($sformatf("pc s%0d", st), pc_w[k], m_pc[k]);
            check($sformatf("pc_step s%0d", st), step_w[k], m_pc[k] + st);
            check($sformatf("epc s%0d", st), epc_w[k], m_epc[k]);
            check($sformatf("ras_empty s%0d", st), 32'(emp_w[k]), 32'(m_ras[k].size() == 0));
            check($sformatf("ras_full s%0d", st), 32'(full_w[k]), 32'(m_ras[k].size() == 4));
            check($sformatf("misaligned s%0d", st), 32'(mis_w[k]), 32'(m_mis[k]));
            check($sformatf("ras_underflow s%0d", st), 32'(uf_w[k]), 32'(m_uf[k]));
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pc[k]  = 32'h0;
            m_epc[k] = 32'h0;
            m_mis[k] = 1'b0;
            m_uf[k]  = 1'b0;
            m_ras[k].delete();
        end
    endtask

    task automatic model_step(input int k, input logic en, input logic [2:0] md,
                              input logic [31:0] ja, input logic [31:0] off);
        logic [31:0] st, t, old;
        logic        bad;
        st = k == 0 ? 32'd4 : 32'd2;
        old = m_pc[k];
        m_mis[k] = 1'b0;
        m_uf[k]  = 1'b0;
        if (!en) return;
        case (md)
            3'd1:       t = old + st;
            3'd2, 3'd4: t = ja;
            3'd3:       t = old + off;
            3'd5:       t = m_ras[k].size() > 0 ? m_ras[k][$] : old + st;
            3'd7:       t = m_epc[k];
            default:    t = old;
        endcase
        bad = (md inside {3'd2, 3'd3, 3'd4, 3'd5, 3'd7}) && (t % st) != 0;
        if (md == 3'd6 || bad) begin
            m_epc[k] = old;
            m_pc[k]  = 32'h100;
            m_mis[k] = bad;
            return;
        end
        m_pc[k] = t;
        if (md == 3'd4) begin
            m_ras[k].push_back(old + st);
            if (m_ras[k].size() > 4) void'(m_ras[k].pop_front());
        end
        if (md == 3'd5) begin
            if (m_ras[k].size() > 0) void'(m_ras[k].pop_back());
            else m_uf[k] = 1'b1;
        end
    endtask

    task automatic cyc(input logic en, input logic [2:0] md, input logic [31:0] ja, input logic [31:0] off);
        enable   = en;
        mode     = md;
        jmp_addr = ja;
        offset   = off;
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_step(k, en, md, ja, off);
        #1 check_all();
    endtask

    task automatic async_reset();
        #2 res_n = 1'b0;
        model_reset();
        #1 check_all();
        @(posedge clk);
        #1 check_all();
        res_n = 1'b1;
    endtask

    initial begin
        res_n = 1'b0;
        enable = 1'b0;
        mode = 3'd0;
        jmp_addr = 32'h0;
        offset = 32'h0;
        model_reset();
        #12 check_all();
        res_n = 1'b1;

        cyc(1, 3'd2, 32'h0000_0040, 0);
        cyc(1, 3'd4, 32'h0000_0200, 0);
        async_reset();
        repeat (3) cyc(1, 3'd1, 0, 0);

        cyc(1, 3'd2, 32'h0000_0040, 0);
        cyc(1, 3'd3, 0, 32'hFFFF_FFF0);
        cyc(1, 3'd2, 32'h0000_1000, 0);
        cyc(1, 3'd2, 32'h0000_1002, 0);
        cyc(1, 3'd0, 0, 0);

        cyc(1, 3'd2, 32'h0000_0010, 0);
        cyc(1, 3'd4, 32'h0000_0200, 0);
        cyc(1, 3'd4, 32'h0000_0300, 0);
        cyc(1, 3'd5, 0, 0);
        cyc(1, 3'd5, 0, 0);

        for (int i = 1; i <= 5; i++) cyc(1, 3'd4, 32'(i) << 12, 0);
        repeat (5) cyc(1, 3'd5, 0, 0);
        cyc(1, 3'd0, 0, 0);

        cyc(1, 3'd2, 32'h0000_0080, 0);
        cyc(1, 3'd6, 0, 0);
        cyc(1, 3'd1, 0, 0);
        cyc(1, 3'd7, 0, 0);
        repeat (3) cyc(0, 3'd1, 0, 0);

        cyc(1, 3'd2, 32'hFFFF_FFFE, 0);
        cyc(1, 3'd1, 0, 0);
        cyc(1, 3'd2, 32'h0000_0102, 0);
        cyc(1, 3'd2, 32'h0000_0103, 0);

        for (int i = 0; i < 400; i++) begin
            logic [31:0] ja, off;
            ja = $urandom;
            if ($urandom_range(0, 4) != 0) ja[1:0] = 2'b00;
            off = 32'($urandom_range(0, 511)) - 32'd256;
            if ($urandom_range(0, 4) != 0) off[1:0] = 2'b00;
            if ($urandom_range(0, 99) == 0) async_reset();
            else cyc($urandom_range(0, 9) != 0, 3'($urandom_range(0, 7)), ja, off);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
